// File: rtl/piso_serializer_if.sv
// piso_serializer_if: word handshake in, framed serial bit stream out
// in_data/in_valid/in_ready: word handshake into the serializer
// ser_d/ser_frame/ser_last/busy: serial bit, frame strobe, last-bit strobe, activity
interface piso_serializer_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] in_data;
  logic in_valid, in_ready, ser_d, ser_frame, ser_last, busy;
  modport master(output in_data, in_valid, input in_ready, ser_d, ser_frame, ser_last, busy);
  modport slave(input in_data, in_valid, output in_ready, ser_d, ser_frame, ser_last, busy);
endinterface

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in/serial-out word serializer with framing strobes
// clk, rst: clock and synchronous active-high reset
// io (slave): in_data/in_valid/in_ready handshake; ser_d/ser_frame/ser_last/busy registered outputs
module piso_serializer #(
  parameter int WIDTH = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int GAP = 1
) (
  input logic clk,
  input logic rst,
  piso_serializer_if.slave io
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;
  state_t state_q;
  logic [WIDTH-1:0] sh_q, load_sh, next_sh;
  logic [CW-1:0] cnt_q;
  logic [3:0] gcnt_q;
  logic d_q, frame_q, last_q, ready_q, busy_q;
  logic accept, load_bit, next_bit;
  assign accept = io.in_valid & ready_q;
  assign io.in_ready = ready_q;
  assign io.ser_d = d_q;
  assign io.ser_frame = frame_q;
  assign io.ser_last = last_q;
  assign io.busy = busy_q;
  // The first bit goes straight to ser_d on accept; the shifter keeps only the rest.
  always_comb begin
    load_bit = MSB_FIRST ? io.in_data[WIDTH-1] : io.in_data[0];
    load_sh = MSB_FIRST ? io.in_data << 1 : io.in_data >> 1;
    next_bit = MSB_FIRST ? sh_q[WIDTH-1] : sh_q[0];
    next_sh = MSB_FIRST ? sh_q << 1 : sh_q >> 1;
  end
  // ready_q can only be high in IDLE or, with no gap, in the last SHIFT cycle,
  // so an accept always restarts a word regardless of the current state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sh_q <= '0;
      cnt_q <= '0;
      gcnt_q <= '0;
      d_q <= 1'b0;
      frame_q <= 1'b0;
      last_q <= 1'b0;
      ready_q <= 1'b0;
      busy_q <= 1'b0;
    end else if (accept) begin
      state_q <= S_SHIFT;
      sh_q <= load_sh;
      cnt_q <= '0;
      d_q <= load_bit;
      frame_q <= 1'b1;
      last_q <= 1'b0;
      ready_q <= 1'b0;
      busy_q <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: ready_q <= 1'b1;
        S_SHIFT:
          if (cnt_q == LAST) begin
            state_q <= GAP > 0 ? S_GAP : S_IDLE;
            gcnt_q <= '0;
            d_q <= 1'b0;
            frame_q <= 1'b0;
            last_q <= 1'b0;
            ready_q <= GAP == 0;
            busy_q <= GAP > 0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            sh_q <= next_sh;
            d_q <= next_bit;
            last_q <= cnt_q + 1'b1 == LAST;
            ready_q <= GAP == 0 && cnt_q + 1'b1 == LAST;
          end
        S_GAP:
          if (gcnt_q == 4'(GAP - 1)) begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
            busy_q <= 1'b0;
          end else gcnt_q <= gcnt_q + 1'b1;
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: table-driven and scoreboard bench for three serializer configurations
module tb_piso_serializer;
  typedef struct packed {logic rdy, d, f, l, b;} obs_t;
  typedef struct {int id; logic d; logic l;} exp_t;
  typedef struct {int id; logic [7:0] data; logic [7:0] bits;} vec_t;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  piso_serializer_if #(.WIDTH(8)) ia();
  piso_serializer_if #(.WIDTH(8)) ib();
  piso_serializer_if #(.WIDTH(8)) ic();
  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP(2)) u_a(.clk(clk), .rst(rst), .io(ia));
  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP(1)) u_b(.clk(clk), .rst(rst), .io(ib));
  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP(0)) u_c(.clk(clk), .rst(rst), .io(ic));
  exp_t sb[$];
  int checks = 0, errors = 0;
  int gaps[3] = '{2, 1, 0};
  int frun[3], lfrun[3], brun[3], lbrun[3], bgap[3], lbgap[3];
  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask
  function automatic obs_t obs(input int id);
    case (id)
      0: return {ia.in_ready, ia.ser_d, ia.ser_frame, ia.ser_last, ia.busy};
      1: return {ib.in_ready, ib.ser_d, ib.ser_frame, ib.ser_last, ib.busy};
      default: return {ic.in_ready, ic.ser_d, ic.ser_frame, ic.ser_last, ic.busy};
    endcase
  endfunction
  task automatic drive(input int id, input logic v, input logic [7:0] d);
    case (id)
      0: begin ia.in_valid = v; ia.in_data = d; end
      1: begin ib.in_valid = v; ib.in_data = d; end
      default: begin ic.in_valid = v; ic.in_data = d; end
    endcase
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // bits[7] is the first bit expected on ser_d, bits[0] the last.
  task automatic send(input int id, input logic [7:0] data, input logic [7:0] bits);
    int n = 0;
    obs_t o;
    drive(id, 1'b1, data);
    o = obs(id);
    while (!o.rdy && n < 64) begin
      step();
      n++;
      o = obs(id);
    end
    chk($sformatf("accept_in_time[%0d]", id), int'(n < 64), 1);
    if (n < 64) for (int k = 7; k >= 0; k--) sb.push_back('{id, bits[k], k == 0});
    step();
  endtask
  function automatic bit active();
    obs_t o;
    o = obs(0) | obs(1) | obs(2);
    return sb.size() != 0 || o.b || o.f;
  endfunction
  task automatic drain();
    int n = 0;
    while (active() && n < 100) begin
      step();
      n++;
    end
    chk("drain_in_time", int'(n < 100), 1);
    step();
    step();
  endtask
  task automatic monitor();
    obs_t o;
    exp_t e;
    bit ok;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        o = obs(i);
        if (rst) begin
          frun[i] = 0;
          brun[i] = 0;
          bgap[i] = 0;
        end else begin
          if (o.f) begin
            frun[i]++;
            ok = sb.size() != 0 ? sb[0].id == i : 1'b0;
            chk($sformatf("frame_expected[%0d]", i), int'(ok), 1);
            if (ok) begin
              e = sb.pop_front();
              chk($sformatf("ser_d[%0d]", i), int'(o.d), int'(e.d));
              chk($sformatf("ser_last[%0d]", i), int'(o.l), int'(e.l));
            end
          end else begin
            if (frun[i] > 0) begin
              lfrun[i] = frun[i];
              frun[i] = 0;
            end
            chk($sformatf("idle_d_last[%0d]", i), int'({o.d, o.l}), 0);
          end
          if (o.b) begin
            brun[i]++;
            if (!o.f) bgap[i]++;
            chk($sformatf("ready_in_busy[%0d]", i), int'(o.rdy), int'(gaps[i] == 0 && o.l));
          end else if (brun[i] > 0) begin
            lbrun[i] = brun[i];
            lbgap[i] = bgap[i];
            brun[i] = 0;
            bgap[i] = 0;
          end
        end
      end
    end
  endtask
  initial begin
    vec_t tbl[8];
    obs_t o;
    tbl = '{'{0, 8'hA5, 8'hA5}, '{1, 8'hA5, 8'hA5}, '{1, 8'h01, 8'h80}, '{1, 8'h0F, 8'hF0},
            '{1, 8'hC8, 8'h13}, '{0, 8'h3C, 8'h3C}, '{2, 8'h96, 8'h96}, '{0, 8'h81, 8'h81}};
    for (int i = 0; i < 3; i++) drive(i, 1'b0, 8'h00);
    fork monitor(); join_none
    step();
    step();
    for (int i = 0; i < 3; i++) chk($sformatf("reset_outputs[%0d]", i), int'(obs(i)), 0);
    rst = 1'b0;
    o = obs(0);
    chk("ready_low_at_release", int'(o.rdy), 0);
    step();
    for (int i = 0; i < 3; i++) begin
      o = obs(i);
      chk($sformatf("ready_after_rst[%0d]", i), int'(o.rdy), 1);
      chk($sformatf("idle_frame[%0d]", i), int'({o.f, o.d}), 0);
    end
    foreach (tbl[i]) begin
      send(tbl[i].id, tbl[i].data, tbl[i].bits);
      drive(tbl[i].id, 1'b0, 8'h00);
      drain();
      chk($sformatf("frame_len[%0d]", i), lfrun[tbl[i].id], 8);
    end
    // GAP=0: valid held across two words, frames must butt together
    send(2, 8'hFF, 8'hFF);
    send(2, 8'h00, 8'h00);
    drive(2, 1'b0, 8'h00);
    drain();
    chk("b2b_frame_run", lfrun[2], 16);
    // GAP=2: two queued words, ready low through 8 shift + 2 gap cycles
    send(0, 8'h3C, 8'h3C);
    send(0, 8'h5A, 8'h5A);
    drive(0, 1'b0, 8'h00);
    drain();
    chk("gap_busy_run", lbrun[0], 10);
    chk("gap_idle_cycles", lbgap[0], 2);
    // reset after bit 3 of 0xC3, with the next word already offered during reset
    send(0, 8'hC3, 8'hC3);
    step();
    step();
    step();
    rst = 1'b1;
    drive(0, 1'b1, 8'h81);
    sb.delete();
    step();
    chk("abort_outputs", int'(obs(0)), 0);
    rst = 1'b0;
    send(0, 8'h81, 8'h81);
    drive(0, 1'b0, 8'h00);
    drain();
    chk("after_abort_frame_len", lfrun[0], 8);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
